// File: rtl/msoc_bus_arbiter.sv
// Round-robin arbiter for the shared mSoC data bus: one-hot registered grant,
// per-grant hold limit with timeout pulse, and a turnaround gap between owners.
module msoc_bus_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         rel,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     bus_busy,
  output logic                     timeout,
  output logic [$clog2(N_REQ)-1:0] to_id
);

  localparam int unsigned IdW   = $clog2(N_REQ);
  localparam int unsigned HoldW = $clog2(HOLD_MAX + 1);

  localparam logic [N_REQ-1:0] OneHot0  = N_REQ'(1);
  localparam logic [IdW-1:0]   PtrRst   = IdW'(N_REQ - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_MAX);
  localparam logic [2:0]       TurnLast = 3'(TURN_CYC);

  typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IdW-1:0]   gnt_id_q, gnt_id_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   to_id_q, to_id_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       turn_cnt_q, turn_cnt_d;
  logic             timeout_q, timeout_d;

  logic             sel_found;
  logic [IdW-1:0]   sel_idx;
  logic [IdW-1:0]   cand;
  logic             own_rel, own_req, hold_at_max;

  // Only the owner's rel/req bits are looked at; non-owner bits cannot disturb OWN.
  assign own_rel     = rel[gnt_id_q];
  assign own_req     = req[gnt_id_q];
  assign hold_at_max = (hold_cnt_q == HoldLast);

  // Rotating priority scan starting just after the last owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = IdW'((32'(ptr_q) + 32'(k)) % N_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state and registered-output decode for the IDLE/OWN/TURN cycle.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    to_id_d    = to_id_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d    = StOwn;
          gnt_d      = OneHot0 << sel_idx;
          gnt_id_d   = sel_idx;
          ptr_d      = sel_idx;
          hold_cnt_d = HoldW'(1);
        end
      end
      StOwn: begin
        if (own_rel || !own_req || hold_at_max) begin
          state_d    = StTurn;
          gnt_d      = '0;
          turn_cnt_d = 3'd1;
          // A release in the limit cycle wins over the timeout.
          if (hold_at_max && !own_rel) begin
            timeout_d = 1'b1;
            to_id_d   = gnt_id_q;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StTurn: begin
        if (turn_cnt_q == TurnLast) begin
          state_d = StIdle;
        end else begin
          turn_cnt_d = turn_cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset; reset drops gnt with no gap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= PtrRst;
      to_id_q    <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
      to_id_q    <= to_id_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign bus_busy = |gnt_q;
  assign timeout  = timeout_q;
  assign to_id    = to_id_q;

endmodule

// File: tb/tb_msoc_bus_arbiter.sv
// Self-checking bench for msoc_bus_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a behavioural model of the bus ownership rules.
module tb_msoc_bus_arbiter;

  localparam int unsigned NReq    = 4;
  localparam int unsigned HoldMax = 16;
  localparam int unsigned TurnCyc = 1;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req, rel;
  logic [3:0] gnt;
  logic [1:0] gnt_id, to_id;
  logic       bus_busy, timeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model: who owns the bus, for how long, and how many idle cycles remain.
  int m_owner, m_owned, m_gap, m_last, m_to_id;
  bit m_tmo, m_new;

  msoc_bus_arbiter #(
    .N_REQ   (NReq),
    .HOLD_MAX(HoldMax),
    .TURN_CYC(TurnCyc)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .bus_busy(bus_busy),
    .timeout (timeout),
    .to_id   (to_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task m_step();
    bit found;
    m_new = 1'b0;
    m_tmo = 1'b0;
    if (!rstn) begin
      m_owner = -1; m_owned = 0; m_gap = 0; m_last = NReq - 1; m_to_id = 0;
    end else if (m_owner >= 0) begin
      if (rel[m_owner] || !req[m_owner] || m_owned == HoldMax) begin
        if (m_owned == HoldMax && !rel[m_owner]) begin
          m_tmo = 1'b1;
          m_to_id = m_owner;
        end
        m_owner = -1;
        m_gap = TurnCyc;
      end else begin
        m_owned++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (req != 0) begin
      found = 1'b0;
      for (int k = 1; k <= NReq; k++) begin
        if (!found && req[(m_last + k) % NReq]) begin
          found = 1'b1;
          m_owner = (m_last + k) % NReq;
        end
      end
      m_last = m_owner;
      m_owned = 1;
      m_new = 1'b1;
    end
  endtask

  // One clock: advance the model at the edge, then compare all outputs 1 ns later.
  task tick();
    @(posedge clk);
    m_step();
    #1;
    chk("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("bus_busy", 32'(bus_busy), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("gnt_id", 32'(gnt_id), 32'(m_owner));
    chk("timeout", 32'(timeout), 32'(m_tmo));
    chk("to_id", 32'(to_id), 32'(m_to_id));
    chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task do_reset();
    rstn = 1'b0; req = '0; rel = '0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    int order[$];
    int low, hi, guard;
    rstn = 1'b0; req = '0; rel = '0;
    m_owner = -1; m_owned = 0; m_gap = 0; m_last = NReq - 1; m_to_id = 0;
    m_tmo = 1'b0; m_new = 1'b0;

    // Reset held two cycles, then a single request from mSoC 2.
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_to_id", 32'(to_id), 32'd0);
    rstn = 1'b1; req = 4'b0100;
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_id", 32'(gnt_id), 32'd2);
    chk("single_busy", 32'(bus_busy), 32'd1);
    tick();
    rel = 4'b0100;
    tick();
    rel = '0;
    chk("rel_low1", 32'(gnt), 32'd0);
    tick();
    chk("rel_low2", 32'(gnt), 32'd0);
    tick();
    chk("rel_regrant", 32'(gnt), 32'h4);
    req = '0;
    repeat (4) tick();

    // Round robin with every owner releasing in its third owned cycle.
    do_reset();
    req = 4'b1111;
    low = 0;
    guard = 0;
    while (order.size() < 5 && guard < 200) begin
      rel = (m_owner >= 0 && m_owned == 3) ? 4'(1 << m_owner) : 4'b0;
      tick();
      guard++;
      if (m_new) begin
        if (order.size() > 0) chk("rr_gap", 32'(low), 32'd2);
        order.push_back(int'(gnt_id));
        low = 0;
      end else if (gnt == 4'b0) begin
        low++;
      end
    end
    rel = '0;
    chk("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(i % 4));

    // Timeout: owner 1 holds its request and never releases.
    do_reset();
    req = 4'b0010;
    tick();
    hi = (gnt == 4'b0010) ? 1 : 0;
    guard = 0;
    while (gnt[1] && guard < 40) begin
      tick();
      guard++;
      if (gnt[1]) hi++;
    end
    chk("tmo_hold", 32'(hi), 32'(HoldMax));
    chk("tmo_pulse", 32'(timeout), 32'd1);
    chk("tmo_id", 32'(to_id), 32'd1);
    tick();
    chk("tmo_single", 32'(timeout), 32'd0);
    tick();
    chk("tmo_regrant", 32'(gnt), 32'h2);
    req = '0;
    repeat (3) tick();

    // Timeout fairness: owner 0 times out while 1 waits.
    do_reset();
    req = 4'b0011;
    tick();
    chk("fair_first", 32'(gnt), 32'h1);
    guard = 0;
    while (gnt != 4'b0 && guard < 40) begin tick(); guard++; end
    chk("fair_tmo_id", 32'(to_id), 32'd0);
    tick(); tick();
    chk("fair_next", 32'(gnt), 32'h2);
    req = '0;
    repeat (3) tick();

    // Release in the limit cycle suppresses the timeout.
    do_reset();
    req = 4'b0010;
    tick();
    guard = 0;
    while (m_owner >= 0 && guard < 40) begin
      rel = (m_owned == HoldMax) ? 4'b0010 : 4'b0;
      tick();
      guard++;
    end
    rel = '0;
    chk("coinc_gnt", 32'(gnt), 32'd0);
    chk("coinc_tmo", 32'(timeout), 32'd0);
    req = '0;
    repeat (3) tick();

    // Reset while mSoC 3 owns the bus.
    do_reset();
    req = 4'b1000;
    tick();
    chk("midrst_own", 32'(gnt), 32'h8);
    tick();
    rstn = 1'b0;
    tick();
    chk("midrst_drop", 32'(gnt), 32'd0);
    rstn = 1'b1; req = 4'b1001;
    tick();
    chk("midrst_first", 32'(gnt), 32'h1);

    // Random traffic, including stray rel bits and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) req = 4'($urandom);
      rel = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      if (m_owner >= 0 && $urandom_range(0, 11) == 0) rel = rel | 4'(1 << m_owner);
      rstn = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
